// File: rtl/texture_tile_renderer_if.sv
// ---------------------------------------------------------------------------
// texture_tile_renderer_if
//
// Pixel/control bundle between the VGA timing side and the texture renderer.
//   master : VGA controller / control plane (drives coordinates and controls,
//            receives colour and hit flag)
//   slave  : texture_tile_renderer
// Signals:
//   DrawX, DrawY   current pixel column / row
//   blank          high = visible pixel
//   frame_start    one-cycle pulse, latches the runtime controls
//   tex_sel        texture to render (SEL_W bits)
//   origin_x/_y    screen position of texel (0,0)
//   scale_shift    texel covers 2^scale_shift x 2^scale_shift pixels
//   red/green/blue registered 4-bit colour
//   pixel_hit      high = opaque texel drove this pixel
// ---------------------------------------------------------------------------
interface texture_tile_renderer_if #(
  parameter int SEL_W = 2
);
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic             blank;
  logic             frame_start;
  logic [SEL_W-1:0] tex_sel;
  logic [9:0]       origin_x;
  logic [9:0]       origin_y;
  logic [1:0]       scale_shift;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;
  logic             pixel_hit;

  modport master (
    output DrawX, DrawY, blank, frame_start, tex_sel,
           origin_x, origin_y, scale_shift,
    input  red, green, blue, pixel_hit
  );

  modport slave (
    input  DrawX, DrawY, blank, frame_start, tex_sel,
           origin_x, origin_y, scale_shift,
    output red, green, blue, pixel_hit
  );
endinterface

// File: rtl/texture_tile_renderer.sv
// ---------------------------------------------------------------------------
// texture_tile_renderer
//
// Maps each VGA pixel coordinate onto a texel of one of NUM_TEX stored
// textures and outputs its palette colour, three clock edges later.
//
// Ports:
//   vga_clk  pixel clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   pix      texture_tile_renderer_if.slave (coordinates, blank, frame_start,
//            runtime controls in; red/green/blue/pixel_hit out)
//
// Parameters: TEX_W, TEX_H (power of two 4..64), NUM_TEX (power of two 1..16),
//   IDX_BITS (palette index width), WRAP_MODE (0 = repeat, 1 = clamp).
//
// Optional feature macro: TEXTURE_TRANSPARENCY_EN
//   defined     -> palette index 0 is a colour key (pixel_hit=0, black)
//   not defined -> index 0 is an ordinary colour
//
// Pipeline:
//   edge 1: texel address, blank and in_range registered
//   edge 2: synchronous ROM read; blank/in_range follow along
//   edge 3: palette lookup into the output registers
// ---------------------------------------------------------------------------
module texture_tile_renderer #(
  parameter int TEX_W     = 16,
  parameter int TEX_H     = 16,
  parameter int NUM_TEX   = 4,
  parameter int IDX_BITS  = 8,
  parameter int WRAP_MODE = 0
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  texture_tile_renderer_if.slave  pix
);

  localparam int U_W    = $clog2(TEX_W);
  localparam int V_W    = $clog2(TEX_H);
  localparam int T_W    = $clog2(NUM_TEX);
  localparam int SEL_W  = (NUM_TEX > 1) ? T_W : 1;
  localparam int ADDR_W = U_W + V_W + T_W;
  localparam int DEPTH  = NUM_TEX * TEX_W * TEX_H;

  // Texture artwork: a fixed pattern per texture (low address bits XOR a
  // per-texture constant) so every texture is distinguishable on screen.
  function automatic logic [IDX_BITS-1:0] rom_init(input int a);
    int tex;
    tex = a >> (U_W + V_W);
    return IDX_BITS'(a ^ (tex * 91));
  endfunction

  // Palette: red = index[3:0], green = index[7:4], blue = inverted XOR of both
  // nibbles (so index 0 is pure blue, not black).
  function automatic logic [11:0] palette(input logic [IDX_BITS-1:0] idx);
    logic [7:0] p;
    p = 8'(idx);
    return {p[3:0], p[7:4], p[3:0] ^ p[7:4] ^ 4'hF};
  endfunction

  logic [IDX_BITS-1:0] rom [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom[gi] = rom_init(gi);
    end
  endgenerate

  // Shadow controls
  logic [SEL_W-1:0]    sh_tex_sel_q,  sh_tex_sel_d;
  logic [9:0]          sh_origin_x_q, sh_origin_x_d;
  logic [9:0]          sh_origin_y_q, sh_origin_y_d;
  logic [1:0]          sh_scale_q,    sh_scale_d;
  // Stage 1
  logic [ADDR_W-1:0]   addr_q,        addr_d;
  logic                blank_d1_q,    blank_d1_d;
  logic                in_range_d1_q, in_range_d1_d;
  // Stage 2
  logic [IDX_BITS-1:0] idx_q,         idx_d;
  logic                blank_d2_q,    blank_d2_d;
  logic                in_range_d2_q, in_range_d2_d;
  // Output stage
  logic [3:0]          red_q,         red_d;
  logic [3:0]          green_q,       green_d;
  logic [3:0]          blue_q,        blue_d;
  logic                pixel_hit_q,   pixel_hit_d;

  // Stage-0 coordinate arithmetic
  logic [10:0]         dx, dy;
  logic signed [10:0]  tx, ty;
  logic                in_range;
  logic                hit_d2;

  always_comb begin
    // Shadows reload on frame_start; the pixel sampled on that same edge
    // still sees the old values because stage 0 reads the _q copies.
    sh_tex_sel_d  = sh_tex_sel_q;
    sh_origin_x_d = sh_origin_x_q;
    sh_origin_y_d = sh_origin_y_q;
    sh_scale_d    = sh_scale_q;
    if (pix.frame_start) begin
      sh_tex_sel_d  = pix.tex_sel;
      sh_origin_x_d = pix.origin_x;
      sh_origin_y_d = pix.origin_y;
      sh_scale_d    = pix.scale_shift;
    end

    // 11-bit two's complement offsets; arithmetic shift keeps negative
    // offsets negative so repeat mode wraps them modulo the texture size.
    dx = {1'b0, pix.DrawX} - {1'b0, sh_origin_x_q};
    dy = {1'b0, pix.DrawY} - {1'b0, sh_origin_y_q};
    tx = $signed(dx) >>> sh_scale_q;
    ty = $signed(dy) >>> sh_scale_q;

    // Clamp: in range exactly when all bits above the texel index
    // (including the sign) are zero, i.e. 0 <= t < size.
    if (WRAP_MODE == 0) begin
      in_range = 1'b1;
    end else begin
      in_range = (tx[10:U_W] == '0) && (ty[10:V_W] == '0);
    end

    // With a single texture the select bit falls off the top in the cast.
    addr_d        = ADDR_W'({sh_tex_sel_q, ty[V_W-1:0], tx[U_W-1:0]});
    blank_d1_d    = pix.blank;
    in_range_d1_d = in_range;

    idx_d         = rom[addr_q];
    blank_d2_d    = blank_d1_q;
    in_range_d2_d = in_range_d1_q;

`ifdef TEXTURE_TRANSPARENCY_EN
    hit_d2 = in_range_d2_q && (idx_q != '0);
`else
    hit_d2 = in_range_d2_q;
`endif

    red_d       = 4'h0;
    green_d     = 4'h0;
    blue_d      = 4'h0;
    pixel_hit_d = 1'b0;
    if (blank_d2_q && hit_d2) begin
      {red_d, green_d, blue_d} = palette(idx_q);
      pixel_hit_d              = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_tex_sel_q  <= '0;
      sh_origin_x_q <= '0;
      sh_origin_y_q <= '0;
      sh_scale_q    <= '0;
      addr_q        <= '0;
      blank_d1_q    <= 1'b0;
      in_range_d1_q <= 1'b0;
      idx_q         <= '0;
      blank_d2_q    <= 1'b0;
      in_range_d2_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      pixel_hit_q   <= 1'b0;
    end else begin
      sh_tex_sel_q  <= sh_tex_sel_d;
      sh_origin_x_q <= sh_origin_x_d;
      sh_origin_y_q <= sh_origin_y_d;
      sh_scale_q    <= sh_scale_d;
      addr_q        <= addr_d;
      blank_d1_q    <= blank_d1_d;
      in_range_d1_q <= in_range_d1_d;
      idx_q         <= idx_d;
      blank_d2_q    <= blank_d2_d;
      in_range_d2_q <= in_range_d2_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      pixel_hit_q   <= pixel_hit_d;
    end
  end

  assign pix.red       = red_q;
  assign pix.green     = green_q;
  assign pix.blue      = blue_q;
  assign pix.pixel_hit = pixel_hit_q;

endmodule

// File: tb/tb_texture_tile_renderer.sv
// ---------------------------------------------------------------------------
// tb_texture_tile_renderer
//
// Directed bench for texture_tile_renderer. Two instances share the same
// stimulus: one in repeat mode, one in clamp mode. Observed values are packed
// as {pixel_hit, red, green, blue}. Expected colours are hand-derived from the
// texture pattern (index = addr[7:0] ^ (tex*0x5B)[7:0]) and the palette
// (r = idx[3:0], g = idx[7:4], b = ~(idx[3:0]^idx[7:4])).
// ---------------------------------------------------------------------------
module tb_texture_tile_renderer;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 vga_clk = ~vga_clk;

  texture_tile_renderer_if #(.SEL_W(2)) if_rep ();
  texture_tile_renderer_if #(.SEL_W(2)) if_clp ();

  texture_tile_renderer #(
    .TEX_W(16), .TEX_H(16), .NUM_TEX(4), .IDX_BITS(8), .WRAP_MODE(0)
  ) dut_rep (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .pix     (if_rep)
  );

  texture_tile_renderer #(
    .TEX_W(16), .TEX_H(16), .NUM_TEX(4), .IDX_BITS(8), .WRAP_MODE(1)
  ) dut_clp (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .pix     (if_clp)
  );

  // Pixel (0,0) of texture 0 has palette index 0: pure blue when drawn.
`ifdef TEXTURE_TRANSPARENCY_EN
  localparam logic [12:0] EXP_IDX0 = 13'h0000;
`else
  localparam logic [12:0] EXP_IDX0 = 13'h100F;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-14s hit/rgb=%h", tag, obs);
    end else begin
      $display("FAIL %-14s got hit/rgb=%h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] out_rep();
    return {if_rep.pixel_hit, if_rep.red, if_rep.green, if_rep.blue};
  endfunction

  function automatic logic [12:0] out_clp();
    return {if_clp.pixel_hit, if_clp.red, if_clp.green, if_clp.blue};
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y,
                       input logic blk, input logic fs);
    if_rep.DrawX = x;  if_rep.DrawY = y;  if_rep.blank = blk;  if_rep.frame_start = fs;
    if_clp.DrawX = x;  if_clp.DrawY = y;  if_clp.blank = blk;  if_clp.frame_start = fs;
  endtask

  task automatic ctrl(input logic [1:0] sel, input logic [9:0] ox,
                      input logic [9:0] oy, input logic [1:0] sc);
    if_rep.tex_sel = sel;  if_rep.origin_x = ox;  if_rep.origin_y = oy;  if_rep.scale_shift = sc;
    if_clp.tex_sel = sel;  if_clp.origin_x = ox;  if_clp.origin_y = oy;  if_clp.scale_shift = sc;
  endtask

  // Single-cycle frame_start pulse with the current controls
  task automatic pulse_frame();
    drive(10'd0, 10'd0, 1'b1, 1'b1);
    tick();
    if_rep.frame_start = 1'b0;
    if_clp.frame_start = 1'b0;
  endtask

  // One isolated pixel: present it, then wait out the 3-edge latency
  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic blk);
    drive(x, y, blk, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    ctrl(2'd0, 10'd0, 10'd0, 2'd0);
    drive(10'd5, 10'd2, 1'b1, 1'b0);

    // Reset held with a visible pixel present
    repeat (4) tick();
    check("rst_rep", out_rep(), 13'h0000);
    check("rst_clp", out_clp(), 13'h0000);

    // Release: texture 0, origin (0,0), 1:1 -> address 0x025
    reset_n = 1'b1;
    pixel(10'd5, 10'd2, 1'b1);
    check("post_rst_rep", out_rep(), 13'h1528);
    check("post_rst_clp", out_clp(), 13'h1528);

    // Repeat tiling: (21,17) -> u=5 v=1, address 0x015; clamp misses
    pixel(10'd21, 10'd17, 1'b1);
    check("tile_rep", out_rep(), 13'h151B);
    check("tile_clp", out_clp(), 13'h0000);

    // Clamp with scale 4: origin (100,50)
    ctrl(2'd0, 10'd100, 10'd50, 2'd2);
    pulse_frame();
    pixel(10'd163, 10'd113, 1'b1);           // tx=ty=15 -> 0x0FF
    check("edge_in_rep", out_rep(), 13'h1FFF);
    check("edge_in_clp", out_clp(), 13'h1FFF);
    pixel(10'd164, 10'd113, 1'b1);           // tx=16: clamp miss, repeat u=0 -> 0x0F0
    check("edge_out_rep", out_rep(), 13'h10F0);
    check("edge_out_clp", out_clp(), 13'h0000);
    pixel(10'd99, 10'd113, 1'b1);            // tx=-1: repeat u=15 -> 0x0FF
    check("neg_sc_rep", out_rep(), 13'h1FFF);
    check("neg_sc_clp", out_clp(), 13'h0000);

    // blank low forces black
    pixel(10'd163, 10'd113, 1'b0);
    check("blank_rep", out_rep(), 13'h0000);
    check("blank_clp", out_clp(), 13'h0000);

    // Back to origin (0,0), texture 0: index 0 at (0,0)
    ctrl(2'd0, 10'd0, 10'd0, 2'd0);
    pulse_frame();
    pixel(10'd0, 10'd0, 1'b1);
    check("idx0_rep", out_rep(), EXP_IDX0);
    check("idx0_clp", out_clp(), EXP_IDX0);

    // tex_sel changes without frame_start: still texture 0 (address 0x043)
    ctrl(2'd3, 10'd0, 10'd0, 2'd0);
    pixel(10'd3, 10'd4, 1'b1);
    check("no_latch_rep", out_rep(), 13'h1348);
    check("no_latch_clp", out_clp(), 13'h1348);

    // frame_start on the same edge as pixel (3,4): that pixel keeps texture 0,
    // the next pixel (0,0) reads address 0x300 (index 0x11)
    drive(10'd3, 10'd4, 1'b1, 1'b1);
    tick();
    drive(10'd0, 10'd0, 1'b1, 1'b0);
    tick();
    tick();
    check("collide_rep", out_rep(), 13'h1348);
    check("collide_clp", out_clp(), 13'h1348);
    tick();
    check("latch_rep", out_rep(), 13'h111F);
    check("latch_clp", out_clp(), 13'h111F);

    // Back-to-back frame_start: texture 1 then 2, last wins -> address 0x200
    ctrl(2'd1, 10'd0, 10'd0, 2'd0);
    drive(10'd0, 10'd0, 1'b1, 1'b1);
    tick();
    ctrl(2'd2, 10'd0, 10'd0, 2'd0);
    tick();
    pixel(10'd0, 10'd0, 1'b1);
    check("b2b_rep", out_rep(), 13'h16B2);
    check("b2b_clp", out_clp(), 13'h16B2);

    // Negative wrap: origin (10,0), pixel (9,0) -> u=15, address 0x00F
    ctrl(2'd0, 10'd10, 10'd0, 2'd0);
    pulse_frame();
    pixel(10'd9, 10'd0, 1'b1);
    check("negwrap_rep", out_rep(), 13'h1F00);
    check("negwrap_clp", out_clp(), 13'h0000);

    // Reset mid-line: outputs clear without waiting for a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_rep", out_rep(), 13'h0000);
    check("midrst_clp", out_clp(), 13'h0000);
    @(negedge vga_clk);
    reset_n = 1'b1;
    #1;
    // Shadows were cleared: origin (0,0) and texture 0 apply again even
    // though the control inputs still request origin (10,0)
    pixel(10'd5, 10'd2, 1'b1);
    check("rst2_rep", out_rep(), 13'h1528);
    check("rst2_clp", out_clp(), 13'h1528);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/texture_tile_renderer.md
# texture_tile_renderer

Parametrised texture renderer for the VGA pixel pipeline. It turns each pixel coordinate into a texel of one of several stored textures and outputs the 4-bit RGB colour. Texture size, number of textures, scale factor and wrap mode are parameters. Placement, scale and texture selection are runtime inputs, latched once per frame. It sits between the VGA controller (DrawX/DrawY/blank) and the frame compositor, which uses `pixel_hit` to layer this texture over others.

## Interface
- `TEX_W`, 16: texture width in texels; power of two, 4..64.
- `TEX_H`, 16: texture height in texels; power of two, 4..64.
- `NUM_TEX`, 4: number of stored textures; power of two, 1..16.
- `IDX_BITS`, 8: palette index width.
- `WRAP_MODE`, 0: 0 = repeat (tile across the screen), 1 = clamp (a single copy; pixels outside it miss).
- `vga_clk` in 1: pixel clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `DrawX` in 10: current pixel column, 0..639.
- `DrawY` in 10: current pixel row, 0..479.
- `blank` in 1: high = visible pixel.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking; latches the runtime controls.
- `tex_sel` in log2(NUM_TEX): requested texture.
- `origin_x` in 10: screen column of texel (0,0).
- `origin_y` in 10: screen row of texel (0,0).
- `scale_shift` in 2: each texel covers 2^scale_shift × 2^scale_shift pixels.
- `red`, `green`, `blue` out 4 each: registered pixel colour.
- `pixel_hit` out 1: high = opaque texel driven this pixel.

## Operation
- **Shadow registers.** `tex_sel`, `origin_x`, `origin_y` and `scale_shift` are copied into shadow registers on any edge where `frame_start`=1. All other logic uses only the shadow copies, so the texture never tears mid-frame.
- **Stage 0 (coordinates).** Subtract the origin as 11-bit two's complement:
  - `dx = DrawX − sh_origin_x`, `dy = DrawY − sh_origin_y`
  - `tx = dx >>> sh_scale`, `ty = dy >>> sh_scale` (arithmetic shift)
- **Repeat mode.**
  - `u = tx[log2(TEX_W)-1:0]`, `v = ty[log2(TEX_H)-1:0]`.
  - Negative offsets therefore wrap modulo the texture size.
  - `in_range` = 1 always.
- **Clamp mode.**
  - `in_range` = (0 ≤ tx < TEX_W) and (0 ≤ ty < TEX_H).
  - When `in_range`=1, u and v are taken the same way as in repeat mode.
- **Address.** `addr = {sh_tex_sel, v, u}`, width log2(NUM_TEX·TEX_W·TEX_H).
- **Stage 1 (ROM).** Synchronous ROM read on posedge `vga_clk`, one cycle, NUM_TEX·TEX_W·TEX_H entries of IDX_BITS. The `blank` and `in_range` flags travel alongside in pipeline registers.
- **Stage 2 (palette and output).** Combinational palette lookup feeds the output registers:
  - When blank_d2=1 and hit_d2=1: output the palette colour and `pixel_hit`=1.
  - Otherwise: output 0/0/0 and `pixel_hit`=0.
- **Reset.** All pipeline registers, shadow registers and outputs go to 0 asynchronously. After reset the block renders texture 0 at origin (0,0) with scale 1:1 until the first `frame_start`.

## Timing
- **Latency.** Fixed at 3 cycles: inputs sampled at edge n appear on `red`/`green`/`blue`/`pixel_hit` after edge n+3.
- **Throughput.** One pixel per clock, no stalls.
- **`frame_start` collision.** When `frame_start` and a pixel sample fall on the same edge, that pixel still uses the old shadow values. The new values apply from edge n+1.
- **Back-to-back `frame_start`.** Each pulse re-latches the controls; the last one wins.
- **Reset mid-line.** Outputs go to 0 immediately. The first valid output comes 3 edges after `reset_n` deasserts.
- **`blank` low.** Forces black and `pixel_hit`=0 regardless of the texel value.

## Configuration
- **`TEXTURE_TRANSPARENCY_EN` defined:**
  - A palette index of 0 is the colour key.
  - `hit_d2` = in_range AND (index ≠ 0).
  - Keyed pixels output 0/0/0 with `pixel_hit`=0.
- **Not defined:** index 0 is an ordinary colour, drawn with `pixel_hit`=1 whenever the pixel is in range and visible.

## Test plan
All scenarios use TEX_W=TEX_H=16 and NUM_TEX=4.
- **Reset:** hold `reset_n`=0 with `blank`=1 → RGB=0, `pixel_hit`=0. Release, then DrawX=5, DrawY=2 → after 3 edges, output = palette[ROM[0x025]].
- **Repeat tiling:** origin (0,0), scale 0, DrawX=21, DrawY=17 → output = palette[ROM[0x015]] (u=5, v=1) at edge n+3.
- **Clamp with scale:** WRAP_MODE=1, origin (100,50), `scale_shift`=2.
  - DrawX=163, DrawY=113 → tx=15, ty=15, address 0x0FF, `pixel_hit`=1.
  - DrawX=164 → `pixel_hit`=0, RGB=0.
- **Frame latch:** `tex_sel` changes 0→3 mid-frame with no `frame_start` → addresses stay in 0x000–0x0FF. After a `frame_start` pulse, the next pixel at (0,0) reads address 0x300.
- **Negative wrap:** origin (10,0), DrawX=9, DrawY=0, repeat mode → u=15, address 0x00F.
- **Transparency:** with `TEXTURE_TRANSPARENCY_EN` defined and a ROM entry = 0 → `pixel_hit`=0, RGB=0. Without the macro → `pixel_hit`=1, RGB=palette[0].
